i2c_bus_monitor: RTL
====================

Name: i2c_bus_monitor

Overview:
- Passive I2C bus observer. Samples scl/sda, which it never drives.
- Decodes START, repeated START, STOP and 9-bit byte frames (8 data bits plus ACK), then pushes one event per occurrence into an internal FIFO.
- Sits on the shared open-drain bus beside i2c_master and the i2c_slave instances. Benches and on-chip debug logic use it to read back the traffic that master and slaves write onto the bus.

Parameters:
- DEPTH, 8, event FIFO entries; power of two, >= 2.
- FILT_LEN, 3, glitch-filter stability length in clk cycles; used only when I2C_MON_GLITCH_FILTER_EN is defined; >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous and active-low.
- scl  input  1  bus clock line, observed only.
- sda  input  1  bus data line, observed only.
- ev_valid  output  1  FIFO head holds a valid event.
- ev_ready  input  1  consumer accepts the head event; a pop happens when ev_valid && ev_ready.
- ev_type  output  2  event type: 0 START, 1 RSTART, 2 BYTE, 3 STOP.
- ev_data  output  8  byte value, MSB first on the wire; 0 for non-BYTE events.
- ev_ack  output  1  BYTE events only: 1 when sda was sampled low on the 9th scl rise.
- ev_first  output  1  BYTE events only: 1 for the first byte after START/RSTART (the address byte).
- ev_trunc  output  1  RSTART/STOP events only: 1 when they aborted a partial byte.
- bus_busy  output  1  high from START until STOP.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n low at a clk edge):
  - Synchronizer and history flops load 1 (idle bus), so no spurious edge is seen after reset.
  - FIFO is flushed; ev_valid=0, level=0, overflow=0, bus_busy=0.
  - Bit counter = 0; FSM goes to IDLE.
  - Reset mid-transfer discards all partial state.
- Input path:
  - 2-flop synchronizer per line (s2), plus one history flop (s3).
  - Edges are evaluated on s2 versus s3.
- Condition detection:
  - START: s3.scl=1, s2.scl=1, sda 1->0.
  - STOP: s3.scl=1, s2.scl=1, sda 0->1.
  - If scl and sda change in the same sample, it is not a START/STOP. If scl rose in that sample, the new sda value is the one sampled.
- FSM states: IDLE, ACTIVE.
  - IDLE + START: push START, bus_busy=1, go to ACTIVE, cnt=0, first=1.
  - IDLE + scl rise: ignored.
  - IDLE + STOP: push STOP with trunc=0.
  - ACTIVE + scl rise: cnt 0..7 shift sda into the data register, MSB first. cnt 8 samples ack = ~sda, pushes BYTE {data, ack, first}, then sets first=0 and cnt=0.
  - ACTIVE + START: push RSTART with trunc=(cnt!=0), cnt=0, first=1, stay in ACTIVE.
  - ACTIVE + STOP: push STOP with trunc=(cnt!=0), bus_busy=0, go to IDLE. A partial byte is never emitted.
- Latency: an event is pushed on the clk edge two cycles after the pin change is first registered; ev_valid and level update on that edge (3 clk edges from the pin change with the filter off).
- FIFO behaviour:
  - First-word fall-through; event fields are valid only while ev_valid=1 and are don't-care otherwise.
  - Push while full and no pop that cycle: event dropped, overflow set to 1 and held until reset, level unchanged.
  - Push and pop in the same cycle, including when full: both occur, level unchanged, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH; event order is preserved.
- At most one event is generated per clk; START/STOP detection cannot coincide with an scl rise.

Optional Feature:
- I2C_MON_GLITCH_FILTER_EN defined:
  - Each synchronized line passes through a per-line counter filter.
  - The filtered value changes only after the raw value has differed from it for FILT_LEN consecutive clk cycles.
  - Edge detection uses the filtered values; latency grows by FILT_LEN cycles.
  - Filter state resets to 1.
- Not defined: no filter logic; FILT_LEN is unused.

Test Plan:
- Write to 0x50 with data 0xA5, slave ACKs both bytes, then STOP -> events START; BYTE data=0xA0 first=1 ack=1; BYTE 0xA5 first=0 ack=1; STOP trunc=0; bus_busy 0->1->0; level returns to 0 after draining with ev_ready=1.
- Read from 0x51 returning 0x3C, master NACKs -> START; BYTE 0xA3 ack=1 first=1; BYTE 0x3C ack=0 first=0; STOP.
- START, 0xA0 ACKed, repeated START, 0xA1 -> START; BYTE 0xA0 first=1; RSTART trunc=0; BYTE 0xA1 first=1; no STOP while bus_busy stays 1.
- START plus 5 bits then STOP; separately, START plus 3 bits then repeated START -> STOP trunc=1 and RSTART trunc=1 respectively, no BYTE event, next byte has first=1.
- DEPTH=8, ev_ready=0, 10 events generated -> level=8, overflow=1 from the 9th push, events 1-8 drained in order. Pulsing reset_n low for one cycle -> level=0, overflow=0, ev_valid=0.
- Macro defined, FILT_LEN=3: 2-cycle sda low pulse while scl high -> no event. 4-cycle pulse -> START then STOP, each delayed by 3 extra cycles versus the unfiltered build.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: decodes START/RSTART/STOP/byte frames into an event FIFO.
// Define I2C_MON_GLITCH_FILTER_EN to add a FILT_LEN-cycle stability filter on both lines.
module i2c_bus_monitor #(
  parameter int DEPTH    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     scl,
  input  logic                     sda,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_type,
  output logic [7:0]               ev_data,
  output logic                     ev_ack,
  output logic                     ev_first,
  output logic                     ev_trunc,
  output logic                     bus_busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] EV_START  = 2'd0;
  localparam logic [1:0] EV_RSTART = 2'd1;
  localparam logic [1:0] EV_BYTE   = 2'd2;
  localparam logic [1:0] EV_STOP   = 2'd3;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       ack;
    logic       first;
    logic       trunc;
  } event_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FILT_LEN < 1) begin : g_bad_params
    $error("i2c_bus_monitor: DEPTH must be a power of two >= 2 and FILT_LEN >= 1");
  end

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_cur_s, sda_cur_s;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_rise_s, start_s, stop_s;

  // two-flop synchronizers, idle-high after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
    end
  end

`ifdef I2C_MON_GLITCH_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic           scl_filt_r, sda_filt_r;
  logic [FCW-1:0] scl_fcnt_r, sda_fcnt_r;

  // a line's filtered value follows the raw value only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_fcnt_r <= '0;
      sda_fcnt_r <= '0;
    end else begin
      if (scl_sync_r[1] != scl_filt_r) begin
        if (scl_fcnt_r == FCW'(FILT_LEN - 1)) begin
          scl_filt_r <= scl_sync_r[1];
          scl_fcnt_r <= '0;
        end else begin
          scl_fcnt_r <= scl_fcnt_r + FCW'(1);
        end
      end else begin
        scl_fcnt_r <= '0;
      end
      if (sda_sync_r[1] != sda_filt_r) begin
        if (sda_fcnt_r == FCW'(FILT_LEN - 1)) begin
          sda_filt_r <= sda_sync_r[1];
          sda_fcnt_r <= '0;
        end else begin
          sda_fcnt_r <= sda_fcnt_r + FCW'(1);
        end
      end else begin
        sda_fcnt_r <= '0;
      end
    end
  end

  assign scl_cur_s = scl_filt_r;
  assign sda_cur_s = sda_filt_r;
`else
  assign scl_cur_s = scl_sync_r[1];
  assign sda_cur_s = sda_sync_r[1];
`endif

  // history flops: one-sample-old view of the lines for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_cur_s;
      sda_prev_r <= sda_cur_s;
    end
  end

  // START/STOP need scl high on both samples, so an scl rise can never coincide with them
  assign scl_rise_s = ~scl_prev_r & scl_cur_s;
  assign start_s    = scl_prev_r & scl_cur_s & sda_prev_r & ~sda_cur_s;
  assign stop_s     = scl_prev_r & scl_cur_s & ~sda_prev_r & sda_cur_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] data_r;
  logic       first_r;
  logic       bus_busy_r;
  logic       push_s;
  event_t     push_ev_s;

  // event generation from the current state and detected bus condition
  always_comb begin
    push_s    = 1'b0;
    push_ev_s = '0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          push_s         = 1'b1;
          push_ev_s.kind = EV_START;
        end else if (stop_s) begin
          push_s         = 1'b1;
          push_ev_s.kind = EV_STOP;
        end else begin
          push_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (start_s) begin
          push_s          = 1'b1;
          push_ev_s.kind  = EV_RSTART;
          push_ev_s.trunc = (bit_cnt_r != 4'd0);
        end else if (stop_s) begin
          push_s          = 1'b1;
          push_ev_s.kind  = EV_STOP;
          push_ev_s.trunc = (bit_cnt_r != 4'd0);
        end else if (scl_rise_s && bit_cnt_r == 4'd8) begin
          push_s          = 1'b1;
          push_ev_s.kind  = EV_BYTE;
          push_ev_s.data  = data_r;
          push_ev_s.ack   = ~sda_cur_s;
          push_ev_s.first = first_r;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // framing FSM: bit counter, shift register and busy flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      data_r     <= 8'd0;
      first_r    <= 1'b0;
      bus_busy_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r    <= ACTIVE;
            bus_busy_r <= 1'b1;
            bit_cnt_r  <= 4'd0;
            first_r    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (start_s) begin
            bit_cnt_r <= 4'd0;
            first_r   <= 1'b1;
          end else if (stop_s) begin
            state_r    <= IDLE;
            bus_busy_r <= 1'b0;
            bit_cnt_r  <= 4'd0;
          end else if (scl_rise_s) begin
            if (bit_cnt_r == 4'd8) begin
              bit_cnt_r <= 4'd0;
              first_r   <= 1'b0;
            end else begin
              data_r    <= {data_r[6:0], sda_cur_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  event_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   level_r, level_nxt_s;
  logic          ev_valid_r, overflow_r;
  logic          full_s, pop_s, accept_s;
  event_t        head_s;

  assign full_s   = (level_r == (AW + 1)'(DEPTH));
  assign pop_s    = ev_valid_r & ev_ready;
  assign accept_s = push_s & (~full_s | pop_s);

  // next occupancy from accepted push and pop
  always_comb begin
    level_nxt_s = level_r;
    case ({accept_s, pop_s})
      2'b10:   level_nxt_s = level_r + (AW + 1)'(1);
      2'b01:   level_nxt_s = level_r - (AW + 1)'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // event storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= push_ev_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      ev_valid_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      level_r    <= level_nxt_s;
      ev_valid_r <= (level_nxt_s != '0);
    end
  end

  assign head_s   = mem_r[rd_ptr_r];
  assign ev_valid = ev_valid_r;
  assign ev_type  = head_s.kind;
  assign ev_data  = head_s.data;
  assign ev_ack   = head_s.ack;
  assign ev_first = head_s.first;
  assign ev_trunc = head_s.trunc;
  assign bus_busy = bus_busy_r;
  assign overflow = overflow_r;
  assign level    = level_r;

endmodule
